arith_operand_sequencer: RTL and testbench

//  Producer side of the ArithCircuit operand interface. Walks the operand ROM, reads each
//  {OpA,OpB} pair through a synchronous-read port and presents it as stable OpA/OpB.

---
 rtl/arith_pkg.sv | 26 ++
 rtl/arith_operand_sequencer_if.sv | 27 ++
 rtl/key_debounce.sv | 66 ++++++
 rtl/arith_operand_sequencer.sv | 159 +++++++++++++++
 tb/tb_arith_operand_sequencer.sv | 362 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/arith_pkg.sv
// Shared types and constants for the arithmetic operand path: sequencer state encoding
// and the {OpA,OpB} ROM word layout.
package arith_pkg;

  typedef enum logic [2:0] {
    FETCH,
    WAIT,
    SETTLE,
    CAPTURE,
    HOLD
  } seq_state_e;

  localparam int OP_W    = 8;
  localparam int ROM_W   = 16;
  localparam int OPA_MSB = 15;
  localparam int OPB_MSB = 7;

  function automatic logic [OP_W-1:0] rom_opa(input logic [ROM_W-1:0] word);
    return word[OPA_MSB -: OP_W];
  endfunction

  function automatic logic [OP_W-1:0] rom_opb(input logic [ROM_W-1:0] word);
    return word[OPB_MSB -: OP_W];
  endfunction

endpackage

// File: rtl/arith_operand_sequencer_if.sv
// ROM read port plus operand/result bundle between the sequencer, the operand ROM
// and ArithCircuit.
interface arith_operand_sequencer_if #(
  parameter int ADDR_W = 4
);
  import arith_pkg::*;

  logic [ADDR_W-1:0] romAddr;
  logic [ROM_W-1:0]  romData;
  logic [OP_W-1:0]   OpA;
  logic [OP_W-1:0]   OpB;
  logic              opValid;
  logic [OP_W-1:0]   aluResult;
  logic [OP_W-1:0]   result;
  logic [ADDR_W-1:0] curAddr;

  modport master (
    output romAddr, OpA, OpB, opValid, result, curAddr,
    input  romData, aluResult
  );

  modport slave (
    input  romAddr, OpA, OpB, opValid, result, curAddr,
    output romData, aluResult
  );

endinterface

// File: rtl/key_debounce.sv
// Raw active-low key to one-cycle press pulse: 2-FF synchroniser, stability down-counter
// and a fired flag so a held key produces exactly one pulse.
module key_debounce #(
  parameter int STABLE_CYC = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic press
);

  localparam int CNT_W = (STABLE_CYC > 2) ? $clog2(STABLE_CYC) : 1;
  // Loaded on the first low cycle, so reaching zero marks the STABLE_CYC-th low cycle.
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(STABLE_CYC - 2);

  logic             key_meta_q, key_sync_q;
  logic             key_prev_q, key_prev_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fired_q, fired_d;
  logic             press_q, press_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_meta_q <= 1'b1;
      key_sync_q <= 1'b1;
    end else begin
      key_meta_q <= key_n;
      key_sync_q <= key_meta_q;
    end
  end

  always_comb begin
    key_prev_d = key_sync_q;
    cnt_d      = cnt_q;
    fired_d    = fired_q;
    press_d    = 1'b0;
    if (key_sync_q != key_prev_q) begin
      cnt_d   = CNT_LOAD;
      fired_d = 1'b0;
    end else if (!key_sync_q) begin
      if (cnt_q != '0) begin
        cnt_d = cnt_q - 1'b1;
      end else if (!fired_q) begin
        press_d = 1'b1;
        fired_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_prev_q <= 1'b1;
      cnt_q      <= CNT_LOAD;
      fired_q    <= 1'b0;
      press_q    <= 1'b0;
    end else begin
      key_prev_q <= key_prev_d;
      cnt_q      <= cnt_d;
      fired_q    <= fired_d;
      press_q    <= press_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/arith_operand_sequencer.sv
// Operand producer for ArithCircuit: steps through the operand ROM on a debounced key
// press or the auto timer, presents OpA/OpB and registers the ALU result for the LEDs.
//
//  state   | meaning
//  FETCH   | romAddr holds the new address; arm the ROM latency counter
//  WAIT    | count ROM latency down, capture romData into OpA/OpB at zero
//  SETTLE  | operands stable, combinational ALU settling
//  CAPTURE | first capture of aluResult
//  HOLD    | pair presented, result tracks aluResult, step moves to next entry
module arith_operand_sequencer
  import arith_pkg::*;
#(
  parameter int ADDR_W       = 4,
  parameter int LAST_ADDR    = 15,
  parameter int ROM_LAT      = 1,
  parameter int DEBOUNCE_CYC = 50000,
  parameter int AUTO_PERIOD  = 50000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic stepKey_n,
  input  logic autoRun,
  arith_operand_sequencer_if.master bus
);

  localparam int TMR_W = (AUTO_PERIOD > 2) ? $clog2(AUTO_PERIOD) : 1;
  localparam logic [TMR_W-1:0]  TMR_LOAD  = TMR_W'(AUTO_PERIOD - 1);
  localparam logic [1:0]        WAIT_LOAD = 2'(ROM_LAT - 1);
  localparam logic [ADDR_W-1:0] LAST      = ADDR_W'(LAST_ADDR);

  logic rst_meta_q, rst_sync_q, rst_int_n;
  logic auto_meta_q, auto_sync_q;
  logic key_press, auto_tc, step_pulse;

  seq_state_e        state_q, state_d;
  logic [TMR_W-1:0]  auto_cnt_q, auto_cnt_d;
  logic [1:0]        wait_cnt_q, wait_cnt_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
  logic [ADDR_W-1:0] next_addr;
  logic [OP_W-1:0]   op_a_q, op_a_d;
  logic [OP_W-1:0]   op_b_q, op_b_d;
  logic [OP_W-1:0]   result_q, result_d;

  // Reset asserts asynchronously but releases two clocks later, in step with clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_meta_q <= 1'b0;
      rst_sync_q <= 1'b0;
    end else begin
      rst_meta_q <= 1'b1;
      rst_sync_q <= rst_meta_q;
    end
  end

  assign rst_int_n = rst_sync_q;

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      auto_meta_q <= 1'b0;
      auto_sync_q <= 1'b0;
    end else begin
      auto_meta_q <= autoRun;
      auto_sync_q <= auto_meta_q;
    end
  end

  key_debounce #(
    .STABLE_CYC(DEBOUNCE_CYC)
  ) u_key_debounce (
    .clk  (clk),
    .rst_n(rst_int_n),
    .key_n(stepKey_n),
    .press(key_press)
  );

  assign auto_tc    = auto_sync_q && (auto_cnt_q == '0);
  assign step_pulse = key_press || auto_tc;
  assign next_addr  = (cur_addr_q == LAST) ? '0 : cur_addr_q + 1'b1;

  always_comb begin
    auto_cnt_d = auto_cnt_q;
    if (!auto_sync_q || auto_tc) begin
      auto_cnt_d = TMR_LOAD;
    end else begin
      auto_cnt_d = auto_cnt_q - 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    rom_addr_d = rom_addr_q;
    cur_addr_d = cur_addr_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    result_d   = result_q;
    case (state_q)
      FETCH: begin
        wait_cnt_d = WAIT_LOAD;
        state_d    = WAIT;
      end
      WAIT: begin
        if (wait_cnt_q == '0) begin
          op_a_d     = rom_opa(bus.romData);
          op_b_d     = rom_opb(bus.romData);
          cur_addr_d = rom_addr_q;
          state_d    = SETTLE;
        end else begin
          wait_cnt_d = wait_cnt_q - 2'd1;
        end
      end
      SETTLE: state_d = CAPTURE;
      CAPTURE: begin
        result_d = bus.aluResult;
        state_d  = HOLD;
      end
      HOLD: begin
        result_d = bus.aluResult;
        // Address moves here so the ROM already sees it throughout FETCH.
        if (step_pulse) begin
          rom_addr_d = next_addr;
          state_d    = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_q    <= FETCH;
      auto_cnt_q <= TMR_LOAD;
      wait_cnt_q <= '0;
      rom_addr_q <= '0;
      cur_addr_q <= '0;
      op_a_q     <= '0;
      op_b_q     <= '0;
      result_q   <= '0;
    end else begin
      state_q    <= state_d;
      auto_cnt_q <= auto_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      rom_addr_q <= rom_addr_d;
      cur_addr_q <= cur_addr_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      result_q   <= result_d;
    end
  end

  assign bus.romAddr = rom_addr_q;
  assign bus.curAddr = cur_addr_q;
  assign bus.OpA     = op_a_q;
  assign bus.OpB     = op_b_q;
  assign bus.opValid = (state_q == SETTLE) || (state_q == CAPTURE) || (state_q == HOLD);
  assign bus.result  = result_q;

endmodule

// File: tb/tb_arith_operand_sequencer.sv
// Directed bench: two sequencers (ROM latency 1 and 3, LAST_ADDR=3, short debounce and
// auto period) share key/autoRun/reset; each has its own ROM pipeline and ALU model.
module tb_arith_operand_sequencer;

  logic clk;
  logic rst_n;
  logic stepKey_n;
  logic autoRun;
  logic alu_xor;
  logic mon_en;
  int   total;
  int   bad;
  logic [3:0] cur_exp;

  logic [15:0] rom [16];
  logic [15:0] pa1, pb1, pb2, pb3;

  arith_operand_sequencer_if #(.ADDR_W(4)) bus_a ();
  arith_operand_sequencer_if #(.ADDR_W(4)) bus_b ();

  arith_operand_sequencer #(
    .ADDR_W(4), .LAST_ADDR(3), .ROM_LAT(1), .DEBOUNCE_CYC(16), .AUTO_PERIOD(8)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .stepKey_n(stepKey_n), .autoRun(autoRun), .bus(bus_a)
  );

  arith_operand_sequencer #(
    .ADDR_W(4), .LAST_ADDR(3), .ROM_LAT(3), .DEBOUNCE_CYC(16), .AUTO_PERIOD(8)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .stepKey_n(stepKey_n), .autoRun(autoRun), .bus(bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    pa1 <= rom[bus_a.romAddr];
    pb1 <= rom[bus_b.romAddr];
    pb2 <= pb1;
    pb3 <= pb2;
  end

  assign bus_a.romData   = pa1;
  assign bus_b.romData   = pb3;
  assign bus_a.aluResult = alu_xor ? (bus_a.OpA ^ bus_a.OpB) : (bus_a.OpA + bus_a.OpB);
  assign bus_b.aluResult = alu_xor ? (bus_b.OpA ^ bus_b.OpB) : (bus_b.OpA + bus_b.OpB);

  function automatic logic [7:0] exp_a(input logic [3:0] i);
    return 8'h12 + {i, 4'h0};
  endfunction

  function automatic logic [7:0] exp_b(input logic [3:0] i);
    return 8'h34 + {4'h0, i};
  endfunction

  function automatic logic [7:0] exp_res(input logic [3:0] i, input logic x);
    return x ? (exp_a(i) ^ exp_b(i)) : (exp_a(i) + exp_b(i));
  endfunction

  function automatic logic [3:0] nxt(input logic [3:0] i);
    return (i == 4'd3) ? 4'd0 : i + 4'd1;
  endfunction

  function automatic logic [3:0] adv(input logic [3:0] i, input int n);
    logic [3:0] r;
    r = i;
    for (int k = 0; k < n; k++) r = nxt(r);
    return r;
  endfunction

  always @(negedge clk) begin
    if (mon_en) begin
      total++;
      if (bus_a.romAddr > 4'd3 || bus_b.romAddr > 4'd3) begin
        bad++;
        $display("FAIL rom_addr_range: a=%0d b=%0d want <=3", bus_a.romAddr, bus_b.romAddr);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press_key(input int len);
    stepKey_n = 1'b0;
    tick(len);
    stepKey_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    stepKey_n = 1'b1;
    autoRun = 1'b0;
    alu_xor = 1'b0;
    tick(3);
    total++;
    if ({bus_a.OpA, bus_a.OpB, bus_a.result, bus_a.romAddr, bus_a.curAddr, bus_a.opValid} !== 37'h0 ||
        {bus_b.OpA, bus_b.OpB, bus_b.result, bus_b.romAddr, bus_b.curAddr, bus_b.opValid} !== 37'h0) begin
      bad++;
      $display("FAIL reset_state: a=%h b=%h want 0",
               {bus_a.OpA, bus_a.OpB, bus_a.result, bus_a.romAddr, bus_a.curAddr, bus_a.opValid},
               {bus_b.OpA, bus_b.OpB, bus_b.result, bus_b.romAddr, bus_b.curAddr, bus_b.opValid});
    end
    rst_n = 1'b1;
    tick(3);
    total++;
    if (bus_a.opValid !== 1'b0 || bus_a.OpA !== 8'h00) begin
      bad++;
      $display("FAIL reset_fetch_a: opValid=%b OpA=%h want 0 00", bus_a.opValid, bus_a.OpA);
    end
    tick(1);
    total++;
    if (bus_a.OpA !== 8'h12 || bus_a.OpB !== 8'h34 || bus_a.opValid !== 1'b1 || bus_a.curAddr !== 4'd0) begin
      bad++;
      $display("FAIL reset_load_a: OpA=%h OpB=%h v=%b cur=%0d want 12 34 1 0",
               bus_a.OpA, bus_a.OpB, bus_a.opValid, bus_a.curAddr);
    end
    tick(1);
    total++;
    if (bus_a.result !== 8'h00 || bus_b.opValid !== 1'b0 || bus_b.OpA !== 8'h00) begin
      bad++;
      $display("FAIL reset_settle: a.result=%h b.v=%b b.OpA=%h want 00 0 00",
               bus_a.result, bus_b.opValid, bus_b.OpA);
    end
    tick(1);
    total++;
    if (bus_a.result !== 8'h46 || bus_b.OpA !== 8'h12 || bus_b.OpB !== 8'h34 || bus_b.opValid !== 1'b1) begin
      bad++;
      $display("FAIL reset_result_a: a.result=%h b.OpA=%h b.OpB=%h b.v=%b want 46 12 34 1",
               bus_a.result, bus_b.OpA, bus_b.OpB, bus_b.opValid);
    end
    tick(1);
    total++;
    if (bus_b.result !== 8'h00) begin
      bad++;
      $display("FAIL reset_result_b_early: got %h want 00", bus_b.result);
    end
    tick(1);
    total++;
    if (bus_b.result !== 8'h46) begin
      bad++;
      $display("FAIL reset_result_b: got %h want 46", bus_b.result);
    end
    cur_exp = 4'd0;
  endtask

  task automatic test_debounce();
    press_key(10);
    tick(30);
    total++;
    if (bus_a.curAddr !== cur_exp || bus_b.curAddr !== cur_exp) begin
      bad++;
      $display("FAIL dbn_short: a=%0d b=%0d want %0d", bus_a.curAddr, bus_b.curAddr, cur_exp);
    end
    press_key(10);
    tick(1);
    press_key(10);
    tick(30);
    total++;
    if (bus_a.curAddr !== cur_exp || bus_b.curAddr !== cur_exp) begin
      bad++;
      $display("FAIL dbn_bounce: a=%0d b=%0d want %0d", bus_a.curAddr, bus_b.curAddr, cur_exp);
    end
    press_key(15);
    tick(30);
    total++;
    if (bus_a.curAddr !== cur_exp || bus_b.curAddr !== cur_exp) begin
      bad++;
      $display("FAIL dbn_15: a=%0d b=%0d want %0d", bus_a.curAddr, bus_b.curAddr, cur_exp);
    end
    press_key(16);
    tick(4);
    total++;
    if (bus_a.curAddr !== cur_exp) begin
      bad++;
      $display("FAIL dbn_16_early: a=%0d want %0d", bus_a.curAddr, cur_exp);
    end
    tick(1);
    total++;
    if (bus_a.curAddr !== nxt(cur_exp) || bus_a.OpA !== exp_a(nxt(cur_exp))) begin
      bad++;
      $display("FAIL dbn_16_advance: cur=%0d OpA=%h want %0d %h",
               bus_a.curAddr, bus_a.OpA, nxt(cur_exp), exp_a(nxt(cur_exp)));
    end
    cur_exp = nxt(cur_exp);
    tick(30);
    press_key(1000);
    tick(30);
    total++;
    if (bus_a.curAddr !== nxt(cur_exp) || bus_b.curAddr !== nxt(cur_exp) ||
        bus_b.result !== exp_res(nxt(cur_exp), 1'b0)) begin
      bad++;
      $display("FAIL dbn_hold: a=%0d b=%0d b.result=%h want %0d %h",
               bus_a.curAddr, bus_b.curAddr, bus_b.result, nxt(cur_exp), exp_res(nxt(cur_exp), 1'b0));
    end
    cur_exp = nxt(cur_exp);
  endtask

  task automatic test_lat3();
    logic [3:0] n;
    int low_cnt;
    n = nxt(cur_exp);
    low_cnt = 0;
    press_key(16);
    tick(1);
    for (int c = 18; c <= 24; c++) begin
      tick(1);
      if (bus_b.opValid === 1'b0) low_cnt++;
      total++;
      if (bus_b.opValid !== !(c >= 19 && c <= 22) ||
          bus_b.OpA !== ((c >= 23) ? exp_a(n) : exp_a(cur_exp)) ||
          bus_b.OpB !== ((c >= 23) ? exp_b(n) : exp_b(cur_exp))) begin
        bad++;
        $display("FAIL lat3_b c=%0d: v=%b OpA=%h OpB=%h", c, bus_b.opValid, bus_b.OpA, bus_b.OpB);
      end
      total++;
      if (bus_a.opValid !== !(c == 19 || c == 20) ||
          bus_a.OpA !== ((c >= 21) ? exp_a(n) : exp_a(cur_exp)) ||
          bus_a.result !== ((c >= 23) ? exp_res(n, 1'b0) : exp_res(cur_exp, 1'b0))) begin
        bad++;
        $display("FAIL lat1_a c=%0d: v=%b OpA=%h result=%h", c, bus_a.opValid, bus_a.OpA, bus_a.result);
      end
    end
    total++;
    if (low_cnt != 4) begin
      bad++;
      $display("FAIL lat3_low_cycles: got %0d want 4", low_cnt);
    end
    cur_exp = n;
    tick(10);
  endtask

  task automatic test_track();
    total++;
    if (bus_a.result !== exp_res(cur_exp, 1'b0)) begin
      bad++;
      $display("FAIL track_add: got %h want %h", bus_a.result, exp_res(cur_exp, 1'b0));
    end
    alu_xor = 1'b1;
    tick(1);
    total++;
    if (bus_a.result !== exp_res(cur_exp, 1'b1) || bus_b.result !== exp_res(cur_exp, 1'b1)) begin
      bad++;
      $display("FAIL track_xor: a=%h b=%h want %h", bus_a.result, bus_b.result, exp_res(cur_exp, 1'b1));
    end
    alu_xor = 1'b0;
    tick(1);
    total++;
    if (bus_a.result !== exp_res(cur_exp, 1'b0)) begin
      bad++;
      $display("FAIL track_back: got %h want %h", bus_a.result, exp_res(cur_exp, 1'b0));
    end
    tick(5);
  endtask

  task automatic test_auto();
    int n_a;
    int n_b;
    autoRun = 1'b1;
    stepKey_n = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      tick(1);
      if (c == 20) stepKey_n = 1'b1;
      if (c == 30) autoRun = 1'b0;
      n_a = int'(c >= 12) + int'(c >= 20) + int'(c >= 28);
      n_b = int'(c >= 14) + int'(c >= 22) + int'(c >= 30);
      total++;
      if (bus_a.curAddr !== adv(cur_exp, n_a) || bus_b.curAddr !== adv(cur_exp, n_b)) begin
        bad++;
        $display("FAIL auto c=%0d: a=%0d b=%0d want %0d %0d",
                 c, bus_a.curAddr, bus_b.curAddr, adv(cur_exp, n_a), adv(cur_exp, n_b));
      end
    end
    cur_exp = adv(cur_exp, 3);
  endtask

  task automatic test_wrap();
    logic [3:0] seq [5];
    seq[0] = 4'd1; seq[1] = 4'd2; seq[2] = 4'd3; seq[3] = 4'd0; seq[4] = 4'd1;
    test_reset();
    mon_en = 1'b1;
    for (int k = 0; k < 5; k++) begin
      press_key(16);
      tick(10);
      total++;
      if (bus_a.curAddr !== seq[k] || bus_b.curAddr !== seq[k] || bus_b.OpA !== exp_a(seq[k])) begin
        bad++;
        $display("FAIL wrap k=%0d: a=%0d b=%0d b.OpA=%h want %0d %h",
                 k, bus_a.curAddr, bus_b.curAddr, bus_b.OpA, seq[k], exp_a(seq[k]));
      end
    end
    mon_en = 1'b0;
    cur_exp = seq[4];
  endtask

  task automatic test_reset_mid();
    press_key(16);
    tick(4);
    total++;
    if (bus_a.opValid !== 1'b0 || bus_b.opValid !== 1'b0) begin
      bad++;
      $display("FAIL rmid_in_fetch: a.v=%b b.v=%b want 0 0", bus_a.opValid, bus_b.opValid);
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({bus_a.OpA, bus_a.OpB, bus_a.result, bus_a.romAddr, bus_a.curAddr, bus_a.opValid} !== 37'h0 ||
        {bus_b.OpA, bus_b.OpB, bus_b.result, bus_b.romAddr, bus_b.curAddr, bus_b.opValid} !== 37'h0) begin
      bad++;
      $display("FAIL rmid_async_clear: a=%h b=%h want 0",
               {bus_a.OpA, bus_a.OpB, bus_a.result, bus_a.romAddr, bus_a.curAddr, bus_a.opValid},
               {bus_b.OpA, bus_b.OpB, bus_b.result, bus_b.romAddr, bus_b.curAddr, bus_b.opValid});
    end
    tick(2);
    rst_n = 1'b1;
    tick(4);
    total++;
    if (bus_a.OpA !== 8'h12 || bus_a.OpB !== 8'h34 || bus_a.curAddr !== 4'd0 || bus_a.opValid !== 1'b1) begin
      bad++;
      $display("FAIL rmid_refetch_a: OpA=%h OpB=%h cur=%0d v=%b want 12 34 0 1",
               bus_a.OpA, bus_a.OpB, bus_a.curAddr, bus_a.opValid);
    end
    tick(2);
    total++;
    if (bus_a.result !== 8'h46 || bus_b.OpA !== 8'h12 || bus_b.curAddr !== 4'd0 || bus_b.opValid !== 1'b1) begin
      bad++;
      $display("FAIL rmid_refetch_b: a.result=%h b.OpA=%h b.cur=%0d b.v=%b want 46 12 0 1",
               bus_a.result, bus_b.OpA, bus_b.curAddr, bus_b.opValid);
    end
    tick(2);
    total++;
    if (bus_b.result !== 8'h46) begin
      bad++;
      $display("FAIL rmid_result_b: got %h want 46", bus_b.result);
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    mon_en = 1'b0;
    cur_exp = 4'd0;
    rst_n = 1'b0;
    stepKey_n = 1'b1;
    autoRun = 1'b0;
    alu_xor = 1'b0;
    for (int i = 0; i < 16; i++) rom[i] = {exp_a(4'(i)), exp_b(4'(i))};
    test_reset();
    test_debounce();
    test_lat3();
    test_track();
    test_auto();
    test_wrap();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
